// File: rtl/dmem_store_sched.sv
// dmem_store_sched: store buffer and port scheduler between two memory-stage
// lanes and a dual-port data memory. Lane stores are queued in a DEPTH-entry
// FIFO and drained through whichever memory ports the cycle's loads leave
// free. Loads read memory combinationally, with forwarding from the buffer
// and (for lane 1) from a same-cycle lane-0 store. Lane 0 is the older lane.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   l0_*/l1_* req,we,addr,wd lane requests (addr[1:0] ignored, word access)
//   l0_rd, l1_rd             combinational load data
//   stall                    this cycle's requests are not accepted
//   empty, count             registered buffer occupancy
//   mem_a/b, mem_wea/b, mem_wda/b, mem_rda/b   dual-port data memory
module dmem_store_sched #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        l0_req,
  input  logic        l0_we,
  input  logic [31:0] l0_addr,
  input  logic [31:0] l0_wd,
  input  logic        l1_req,
  input  logic        l1_we,
  input  logic [31:0] l1_addr,
  input  logic [31:0] l1_wd,
  output logic [31:0] l0_rd,
  output logic [31:0] l1_rd,
  output logic        stall,
  output logic        empty,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0] count,
  output logic [31:0] mem_a,
  output logic [31:0] mem_b,
  output logic        mem_wea,
  output logic        mem_web,
  output logic [31:0] mem_wda,
  output logic [31:0] mem_wdb,
  input  logic [31:0] mem_rda,
  input  logic [31:0] mem_rdb
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = 30;

  logic [AW-1:0] buf_addr [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic          st0, st1, ld0, ld1;
  logic [1:0]    n_st;
  logic [CW-1:0] free;
  logic          stall_c;
  logic          push0, push1;
  logic [1:0]    pushes, pops;
  logic          drain_a, drain_b;
  logic [PW-1:0] idx_a, idx_b;
  logic          fwd0_hit, fwd1_hit;
  logic [31:0]   fwd0_data, fwd1_data;
  logic          l0_to_l1;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{l0_addr[1:0], l1_addr[1:0]};

  // Store acceptance: all-or-nothing against the free space at cycle start
  assign st0     = l0_req & l0_we;
  assign st1     = l1_req & l1_we;
  assign ld0     = l0_req & ~l0_we;
  assign ld1     = l1_req & ~l1_we;
  assign n_st    = {1'b0, st0} + {1'b0, st1};
  assign free    = CW'(DEPTH) - cnt;
  assign stall_c = CW'(n_st) > free;
  assign push0   = st0 & ~stall_c;
  assign push1   = st1 & ~stall_c;
  assign pushes  = {1'b0, push0} + {1'b0, push1};

  // Drain scheduling: port A takes the oldest entry, port B the next one.
  // reset_n gates the enables so an asserted reset kills in-flight writes.
  assign drain_a = reset_n & ~ld0 & (cnt != '0);
  assign drain_b = reset_n & ~ld1 & (cnt > CW'(drain_a));
  assign idx_a   = head;
  assign idx_b   = head + PW'(drain_a);
  assign pops    = {1'b0, drain_a} + {1'b0, drain_b};

  // Memory port drive; idle or load-owned ports carry the lane address
  always_comb begin
    mem_a   = l0_addr;
    mem_b   = l1_addr;
    mem_wea = 1'b0;
    mem_web = 1'b0;
    mem_wda = '0;
    mem_wdb = '0;
    if (drain_a) begin
      mem_a   = {buf_addr[idx_a], 2'b00};
      mem_wea = 1'b1;
      mem_wda = buf_data[idx_a];
    end
    if (drain_b) begin
      mem_b   = {buf_addr[idx_b], 2'b00};
      mem_web = 1'b1;
      mem_wdb = buf_data[idx_b];
    end
  end

  // Buffer forwarding: walk oldest to youngest so the youngest match wins.
  // Entries draining this cycle are still counted and still forward.
  always_comb begin
    fwd0_hit  = 1'b0;
    fwd1_hit  = 1'b0;
    fwd0_data = '0;
    fwd1_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        if (buf_addr[head + PW'(i)] == l0_addr[31:2]) begin
          fwd0_hit  = 1'b1;
          fwd0_data = buf_data[head + PW'(i)];
        end
        if (buf_addr[head + PW'(i)] == l1_addr[31:2]) begin
          fwd1_hit  = 1'b1;
          fwd1_data = buf_data[head + PW'(i)];
        end
      end
    end
  end

  // Lane 1 sees an accepted same-cycle lane-0 store ahead of the buffer
  assign l0_to_l1 = reset_n & push0 & (l0_addr[31:2] == l1_addr[31:2]);

  assign l0_rd = fwd0_hit ? fwd0_data : mem_rda;
  assign l1_rd = l0_to_l1 ? l0_wd : (fwd1_hit ? fwd1_data : mem_rdb);

  assign stall = stall_c;
  assign empty = (cnt == '0);
  assign count = cnt;

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(pops);
      tail <= tail + PW'(pushes);
      cnt  <= cnt + CW'(pushes) - CW'(pops);
    end
  end

  // Entry storage, lane 0 lands first when both lanes push
  always_ff @(posedge clk) begin
    if (push0) begin
      buf_addr[tail] <= l0_addr[31:2];
      buf_data[tail] <= l0_wd;
    end
    if (push1) begin
      buf_addr[tail + PW'(push0)] <= l1_addr[31:2];
      buf_data[tail + PW'(push0)] <= l1_wd;
    end
  end

endmodule
